// File: rtl/wrr_pkg.sv
// Shared constants, scheduler state encoding and helpers for the
// weighted round-robin virtual-channel scheduler.
package wrr_pkg;
  localparam int NUM_VC         = 4;
  localparam int VC_W           = 2;
  localparam int WEIGHT_W       = 3;
  localparam int DEFAULT_WEIGHT = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  function automatic logic [NUM_VC-1:0] onehot(input logic [VC_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/wrr_vc_scheduler_credit.sv
// Per-VC downstream credit counter: decrements on a pop, increments on a
// credit return, saturates at MAX_CREDIT and flags a return that overflows.
module vc_credit_counter #(
  parameter int MAX_CREDIT = 4,
  parameter int CREDIT_W   = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic dec_i,
  input  logic inc_i,
  output logic nonzero_o,
  output logic overflow_o
);
  localparam logic [CREDIT_W-1:0] MaxC = CREDIT_W'(MAX_CREDIT);

  logic [CREDIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (dec_i && !inc_i && count_q != '0)
      count_d = count_q - 1'b1;
    else if (inc_i && !dec_i && count_q != MaxC)
      count_d = count_q + 1'b1;
  end

  assign nonzero_o  = (count_q != '0);
  assign overflow_o = inc_i && !dec_i && (count_q == MaxC);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) count_q <= MaxC;
    else         count_q <= count_d;
  end
endmodule

// File: rtl/wrr_vc_scheduler.sv
// Weighted round-robin scheduler sharing one link among 4 VCs, with a
// programmable weight table and per-VC credit tracking. One registered pop per cycle.
module wrr_vc_scheduler #(
  parameter int WEIGHT_W   = 3,
  parameter int MAX_CREDIT = 4,
  parameter int CREDIT_W   = 3
) (
  input  logic                CLK_2MHz,
  input  logic                reset,
  input  logic                edit_weight,
  input  logic [1:0]          vc_assign,
  input  logic [WEIGHT_W-1:0] weight_assign,
  input  logic [3:0]          vc_req,
  input  logic [3:0]          credit_return,
  output logic [3:0]          vc_grant,
  output logic [1:0]          grant_vc,
  output logic                grant_valid,
  output logic                credit_err
);
  import wrr_pkg::*;

  state_e              state_q;
  logic [VC_W-1:0]     cur_vc_q;
  logic [WEIGHT_W-1:0] quota_q;
  logic [WEIGHT_W-1:0] weight_q [NUM_VC];
  logic [NUM_VC-1:0]   vc_grant_q;
  logic [VC_W-1:0]     grant_vc_q;
  logic                grant_valid_q;
  logic                credit_err_q;

  logic [NUM_VC-1:0]   elig, nonzero, overflow, dec;
  logic                do_grant, found;
  logic [VC_W-1:0]     next_vc, idx;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_credit
    vc_credit_counter #(
      .MAX_CREDIT (MAX_CREDIT),
      .CREDIT_W   (CREDIT_W)
    ) u_cnt (
      .clk_i      (CLK_2MHz),
      .rst_ni     (reset),
      .dec_i      (dec[i]),
      .inc_i      (credit_return[i]),
      .nonzero_o  (nonzero[i]),
      .overflow_o (overflow[i])
    );
    assign elig[i] = vc_req[i] && nonzero[i] && (weight_q[i] != '0);
  end

  assign do_grant = !edit_weight && (state_q == SERVE) && elig[cur_vc_q] && (quota_q != '0);
  assign dec      = do_grant ? onehot(cur_vc_q) : '0;

  // Cyclic search from cur_vc+1 round to cur_vc; the nearest eligible VC wins.
  always_comb begin
    found   = 1'b0;
    next_vc = cur_vc_q;
    idx     = cur_vc_q;
    for (int k = NUM_VC; k >= 1; k--) begin
      idx = cur_vc_q + VC_W'(k);
      if (elig[idx]) begin
        found   = 1'b1;
        next_vc = idx;
      end
    end
  end

  always_ff @(posedge CLK_2MHz) begin
    if (!reset) begin
      state_q       <= IDLE;
      cur_vc_q      <= VC_W'(NUM_VC - 1);
      quota_q       <= '0;
      vc_grant_q    <= '0;
      grant_vc_q    <= '0;
      grant_valid_q <= 1'b0;
      credit_err_q  <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) weight_q[i] <= WEIGHT_W'(DEFAULT_WEIGHT);
    end else begin
      vc_grant_q    <= '0;
      grant_valid_q <= 1'b0;
      if (|overflow) credit_err_q <= 1'b1;
      if (edit_weight) begin
        weight_q[vc_assign] <= weight_assign;
      end else if (do_grant) begin
        vc_grant_q    <= onehot(cur_vc_q);
        grant_vc_q    <= cur_vc_q;
        grant_valid_q <= 1'b1;
        quota_q       <= quota_q - 1'b1;
      end else if (found) begin
        // Switching VCs costs this cycle as a bubble; the grant follows next cycle.
        cur_vc_q <= next_vc;
        quota_q  <= weight_q[next_vc];
        state_q  <= SERVE;
      end else begin
        state_q <= IDLE;
        quota_q <= '0;
      end
    end
  end

  assign vc_grant    = vc_grant_q;
  assign grant_vc    = grant_vc_q;
  assign grant_valid = grant_valid_q;
  assign credit_err  = credit_err_q;
endmodule

// File: tb/tb_wrr_vc_scheduler.sv
// Bench for wrr_vc_scheduler: cycle model of the scheduling rules plus
// directed scenarios with literal grant sequences.
module tb_wrr_vc_scheduler;
  localparam int MAXC = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       edit;
  logic [1:0] vca;
  logic [2:0] wa;
  logic [3:0] req;
  logic [3:0] ret_man;
  logic       loopback;
  logic [3:0] ret;
  logic [3:0] vc_grant;
  logic [1:0] grant_vc;
  logic       grant_valid;
  logic       credit_err;

  assign ret = ret_man | (loopback ? vc_grant : 4'b0000);

  always #5 clk = ~clk;

  wrr_vc_scheduler #(.WEIGHT_W(3), .MAX_CREDIT(MAXC), .CREDIT_W(3)) dut (
    .CLK_2MHz      (clk),
    .reset         (rst_n),
    .edit_weight   (edit),
    .vc_assign     (vca),
    .weight_assign (wa),
    .vc_req        (req),
    .credit_return (ret),
    .vc_grant      (vc_grant),
    .grant_vc      (grant_vc),
    .grant_valid   (grant_valid),
    .credit_err    (credit_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: weights, credits, turn pointer and remaining quota as plain ints.
  int  m_w[4];
  int  m_cr[4];
  int  m_cur, m_quota, e_vc, gvc, nxt;
  bit  m_serve, m_err, model_ready = 1'b0, was_reset;

  function automatic bit el(input int i);
    return req[i] && (m_cr[i] > 0) && (m_w[i] > 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin m_w[i] = 1; m_cr[i] = MAXC; end
      m_cur = 3; m_quota = 0; m_serve = 0; m_err = 0; e_vc = -1;
      model_ready = 1'b1; was_reset = 1'b1;
    end else if (model_ready) begin
      was_reset = 1'b0;
      gvc = -1;
      if (!edit) begin
        if (m_serve && m_quota > 0 && el(m_cur)) begin
          gvc = m_cur;
          m_quota = m_quota - 1;
        end else begin
          nxt = -1;
          for (int s = 1; s <= 4; s++)
            if (nxt < 0 && el((m_cur + s) % 4)) nxt = (m_cur + s) % 4;
          if (nxt >= 0) begin m_cur = nxt; m_quota = m_w[nxt]; m_serve = 1; end
          else begin m_serve = 0; m_quota = 0; end
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (gvc == i && !ret[i]) m_cr[i] = m_cr[i] - 1;
        else if (ret[i] && gvc != i) begin
          if (m_cr[i] == MAXC) m_err = 1;
          else m_cr[i] = m_cr[i] + 1;
        end
      end
      if (edit) m_w[vca] = int'(wa);
      e_vc = gvc;
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_ready) begin
      chk("m_grant_valid", int'(grant_valid), (e_vc >= 0) ? 1 : 0);
      chk("m_vc_grant", int'(vc_grant), (e_vc >= 0) ? (1 << e_vc) : 0);
      if (e_vc >= 0) chk("m_grant_vc", int'(grant_vc), e_vc);
      if (was_reset) chk("m_reset_grant_vc", int'(grant_vc), 0);
      chk("m_credit_err", int'(credit_err), int'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int code();
    return grant_valid ? int'(grant_vc) : -1;
  endfunction

  task automatic seq(input string nm, input int exp[$]);
    foreach (exp[k]) begin
      tick();
      chk($sformatf("%s[%0d]", nm, k), code(), exp[k]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wr(input int v, input int w);
    edit = 1'b1; vca = 2'(v); wa = 3'(w);
    tick();
    chk($sformatf("edit_nogrant_vc%0d", v), int'(grant_valid), 0);
    edit = 1'b0;
  endtask

  int ngr;

  initial begin
    rst_n = 1'b0; edit = 1'b0; vca = '0; wa = '0;
    req = '0; ret_man = '0; loopback = 1'b0;
    tick(); tick();
    chk("rst_vc_grant", int'(vc_grant), 0);
    chk("rst_grant_vc", int'(grant_vc), 0);
    chk("rst_grant_valid", int'(grant_valid), 0);
    chk("rst_credit_err", int'(credit_err), 0);
    rst_n = 1'b1;

    // Program weights (vc0 written twice), then read them back through scheduling.
    req = 4'hF; loopback = 1'b1;
    wr(0, 3); wr(1, 4); wr(2, 1); wr(0, 2);
    seq("wrr", '{-1, 0, 0, -1, 1, 1, 1, 1, -1, 2, -1, 3, -1, 0, 0, -1});

    // Credit exhaustion on a lone VC.
    req = '0; loopback = 1'b0;
    do_reset();
    wr(0, 7);
    req = 4'b0001;
    ngr = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (grant_valid) ngr++;
    end
    chk("exhaust_grants", ngr, 4);
    ret_man = 4'b0001;
    seq("ret_pulse", '{-1});
    ret_man = '0;
    seq("after_ret", '{-1, 0, -1, -1});
    chk("exhaust_err", int'(credit_err), 0);

    // Grant and return overlapping on vc1, weight 4.
    do_reset();
    wr(1, 4);
    loopback = 1'b1; req = 4'b0010;
    seq("vc1_burst", '{-1, 1, 1, 1, 1, -1, 1, 1, 1, 1, -1, 1});
    chk("burst_err", int'(credit_err), 0);

    // Credit return overflow on an idle, full VC.
    req = '0; loopback = 1'b0;
    do_reset();
    ret_man = 4'b0100;
    tick();
    ret_man = '0;
    chk("ovf_set", int'(credit_err), 1);
    tick(); tick(); tick();
    chk("ovf_sticky", int'(credit_err), 1);
    do_reset();
    chk("ovf_cleared", int'(credit_err), 0);

    // Disabled vc2, request drop mid-quota on vc1.
    wr(1, 4); wr(2, 0);
    loopback = 1'b1; req = 4'hF;
    seq("drop_a", '{-1, 0, -1, 1, 1});
    req = 4'b1101;
    seq("drop_b", '{-1, 3, -1, 0});
    req = 4'hF;
    seq("drop_c", '{-1, 1, 1, 1, 1, -1, 3, -1, 0});

    // Reset in the middle of a vc1 burst.
    seq("pre_rst", '{-1, 1, 1});
    rst_n = 1'b0;
    tick();
    chk("midrst_valid", int'(grant_valid), 0);
    chk("midrst_vc_grant", int'(vc_grant), 0);
    chk("midrst_grant_vc", int'(grant_vc), 0);
    chk("midrst_err", int'(credit_err), 0);
    rst_n = 1'b1;
    seq("post_rst", '{-1, 0, -1, 1, -1, 2, -1, 3, -1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
